alu_ctrl_sequencer: RTL and testbench

- Fetch/decode/execute controller for the 4-bit processor: the issuing end of the ALU interface.
- Fetches 8-bit instruction bytes from program ROM and drives the ALU function select (F) and operand-bus source.
- Consumes the ALU's C/Z outputs into a registered flag pair that gates conditional jumps.
- Sits between program ROM, data RAM, accumulator/output registers and the ALU.

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_decode.sv | 78 +++++++
 rtl/alu_ctrl_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU/operand-bus codes, state encoding and control-word layout
// for the 4-bit processor fetch/decode/execute controller.
package ctrl_pkg;

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;

  localparam logic [3:0] ALU_F_PASSA = 4'b0000;
  localparam logic [3:0] ALU_F_SUB   = 4'b0001;
  localparam logic [3:0] ALU_F_PASSB = 4'b0010;
  localparam logic [3:0] ALU_F_ADD   = 4'b0011;
  localparam logic [3:0] ALU_F_NAND  = 4'b0100;

  localparam logic [1:0] BSEL_IMM = 2'b00;
  localparam logic [1:0] BSEL_RAM = 2'b01;
  localparam logic [1:0] BSEL_IN  = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_OPERAND = 2'd1,
    ST_EXECUTE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    JK_NONE   = 3'd0,
    JK_C      = 3'd1,
    JK_NC     = 3'd2,
    JK_Z      = 3'd3,
    JK_NZ     = 3'd4,
    JK_ALWAYS = 3'd5
  } jump_kind_t;

  // All-zero word is the idle control word driven outside EXECUTE.
  typedef struct packed {
    logic [3:0] alu_f;
    logic [1:0] b_sel;
    logic       acc_en;
    logic       out_en;
    logic       we_en;
    logic       flag_en;
    jump_kind_t jump_kind;
  } ctrl_word_t;

  function automatic logic is_two_byte(input logic [3:0] op);
    case (op)
      OP_JC, OP_JNC, OP_CMPM, OP_LD, OP_ST,
      OP_JZ, OP_JNZ, OP_ADDM, OP_JMP, OP_NANDM: is_two_byte = 1'b1;
      default:                                  is_two_byte = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps an opcode nibble to the EXECUTE-cycle control word.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] i_opcode,
  output ctrl_word_t o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_JC:    o_ctrl.jump_kind = JK_C;
      OP_JNC:   o_ctrl.jump_kind = JK_NC;
      OP_JZ:    o_ctrl.jump_kind = JK_Z;
      OP_JNZ:   o_ctrl.jump_kind = JK_NZ;
      OP_JMP:   o_ctrl.jump_kind = JK_ALWAYS;
      OP_CMPI: begin
        o_ctrl.alu_f   = ALU_F_SUB;
        o_ctrl.b_sel   = BSEL_IMM;
        o_ctrl.flag_en = 1'b1;
      end
      OP_CMPM: begin
        o_ctrl.alu_f   = ALU_F_SUB;
        o_ctrl.b_sel   = BSEL_RAM;
        o_ctrl.flag_en = 1'b1;
      end
      OP_LIT: begin
        o_ctrl.alu_f  = ALU_F_PASSB;
        o_ctrl.b_sel  = BSEL_IMM;
        o_ctrl.acc_en = 1'b1;
      end
      OP_IN: begin
        o_ctrl.alu_f  = ALU_F_PASSB;
        o_ctrl.b_sel  = BSEL_IN;
        o_ctrl.acc_en = 1'b1;
      end
      OP_LD: begin
        o_ctrl.alu_f  = ALU_F_PASSB;
        o_ctrl.b_sel  = BSEL_RAM;
        o_ctrl.acc_en = 1'b1;
      end
      OP_ST: begin
        o_ctrl.alu_f = ALU_F_PASSA;
        o_ctrl.we_en = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.alu_f   = ALU_F_ADD;
        o_ctrl.b_sel   = BSEL_IMM;
        o_ctrl.acc_en  = 1'b1;
        o_ctrl.flag_en = 1'b1;
      end
      OP_ADDM: begin
        o_ctrl.alu_f   = ALU_F_ADD;
        o_ctrl.b_sel   = BSEL_RAM;
        o_ctrl.acc_en  = 1'b1;
        o_ctrl.flag_en = 1'b1;
      end
      OP_OUT: begin
        o_ctrl.alu_f  = ALU_F_PASSA;
        o_ctrl.out_en = 1'b1;
      end
      OP_NANDI: begin
        o_ctrl.alu_f   = ALU_F_NAND;
        o_ctrl.b_sel   = BSEL_IMM;
        o_ctrl.acc_en  = 1'b1;
        o_ctrl.flag_en = 1'b1;
      end
      OP_NANDM: begin
        o_ctrl.alu_f   = ALU_F_NAND;
        o_ctrl.b_sel   = BSEL_RAM;
        o_ctrl.acc_en  = 1'b1;
        o_ctrl.flag_en = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Fetch/decode/execute sequencer driving the ALU interface of the 4-bit processor.
// Optional single-step control (run/step ports) enabled by defining CTRL_STEP_EN.
module alu_ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic              clock,
  input  logic              reset,
`ifdef CTRL_STEP_EN
  input  logic              run,
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              alu_c,
  input  logic              alu_z,
  output logic [3:0]        alu_f,
  output logic [1:0]        b_sel,
  output logic [3:0]        imm,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              acc_load,
  output logic              out_load,
  output logic              flag_c,
  output logic              flag_z
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;
  logic [7:0]        r_adr;
  logic              r_flag_c;
  logic              r_flag_z;
  ctrl_word_t        r_cw;

  logic [3:0]        w_dec_op;
  ctrl_word_t        w_cw;
  logic              w_taken;
  logic              w_go;
  logic [ADDR_W-1:0] w_jump_target;

  // Decode the byte on the bus while fetching, otherwise the latched opcode.
  assign w_dec_op      = (r_state == ST_FETCH) ? prog_data[7:4] : r_ir[7:4];
  assign w_jump_target = ADDR_W'({r_ir[3:0], r_adr});

  ctrl_decode u_decode (
    .i_opcode (w_dec_op),
    .o_ctrl   (w_cw)
  );

  always_comb begin
    w_taken = 1'b0;
    case (r_cw.jump_kind)
      JK_C:      w_taken = r_flag_c;
      JK_NC:     w_taken = ~r_flag_c;
      JK_Z:      w_taken = r_flag_z;
      JK_NZ:     w_taken = ~r_flag_z;
      JK_ALWAYS: w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end

`ifdef CTRL_STEP_EN
  logic r_step_q;
  logic r_step_pend;
  logic w_step_rise;

  assign w_step_rise = step & ~r_step_q;
  assign w_go        = run | r_step_pend;

  // A detected step edge arms exactly one instruction fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_step_q    <= 1'b0;
      r_step_pend <= 1'b0;
    end else begin
      r_step_q <= step;
      if (w_step_rise)
        r_step_pend <= 1'b1;
      else if (r_state == ST_FETCH)
        r_step_pend <= 1'b0;
    end
  end
`else
  assign w_go = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_FETCH;
      r_pc     <= ADDR_W'(RESET_VECTOR);
      r_ir     <= '0;
      r_adr    <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      r_cw     <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_go) begin
            r_ir <= prog_data;
            r_pc <= r_pc + ADDR_W'(1);
            if (is_two_byte(prog_data[7:4])) begin
              r_state <= ST_OPERAND;
            end else begin
              r_state <= ST_EXECUTE;
              r_cw    <= w_cw;
            end
          end
        end
        ST_OPERAND: begin
          r_adr   <= prog_data;
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= ST_EXECUTE;
          r_cw    <= w_cw;
        end
        ST_EXECUTE: begin
          if (r_cw.flag_en) begin
            r_flag_c <= alu_c;
            r_flag_z <= alu_z;
          end
          if (w_taken)
            r_pc <= w_jump_target;
          r_cw    <= '0;
          r_state <= ST_FETCH;
        end
        default: begin
          r_cw    <= '0;
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign prog_addr = r_pc;
  assign alu_f     = r_cw.alu_f;
  assign b_sel     = r_cw.b_sel;
  assign acc_load  = r_cw.acc_en;
  assign out_load  = r_cw.out_en;
  assign ram_we    = r_cw.we_en;
  assign imm       = r_ir[3:0];
  assign ram_addr  = w_jump_target;
  assign flag_c    = r_flag_c;
  assign flag_z    = r_flag_z;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Self-checking bench for alu_ctrl_sequencer: directed scenarios followed by a
// random program, checked against an instruction-level reference model.
module tb_alu_ctrl_sequencer;

  logic        clock;
  logic        reset;
  logic [11:0] prog_addr;
  logic [7:0]  prog_data;
  logic        alu_c, alu_z;
  logic [3:0]  alu_f;
  logic [1:0]  b_sel;
  logic [3:0]  imm;
  logic [11:0] ram_addr;
  logic        ram_we, acc_load, out_load, flag_c, flag_z;
`ifdef CTRL_STEP_EN
  logic        run, step;
  assign run  = 1'b1;
  assign step = 1'b0;
`endif

  logic [7:0]  rom [0:4095];
  assign prog_data = rom[prog_addr];

  int n_vec = 0;
  int n_bad = 0;

  logic [11:0] m_pc;
  logic        m_fc, m_fz;

  alu_ctrl_sequencer #(.ADDR_W(12), .RESET_VECTOR(0)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef CTRL_STEP_EN
    .run       (run),
    .step      (step),
`endif
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .alu_c     (alu_c),
    .alu_z     (alu_z),
    .alu_f     (alu_f),
    .b_sel     (b_sel),
    .imm       (imm),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .acc_load  (acc_load),
    .out_load  (out_load),
    .flag_c    (flag_c),
    .flag_z    (flag_z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected EXECUTE-cycle outputs {alu_f, b_sel, acc_load, out_load, ram_we}.
  function automatic logic [8:0] exp_exec(input logic [3:0] op);
    case (op)
      4'h2: return {4'b0001, 2'b00, 3'b000};
      4'h3: return {4'b0001, 2'b01, 3'b000};
      4'h4: return {4'b0010, 2'b00, 3'b100};
      4'h5: return {4'b0010, 2'b10, 3'b100};
      4'h6: return {4'b0010, 2'b01, 3'b100};
      4'h7: return {4'b0000, 2'b00, 3'b001};
      4'hA: return {4'b0011, 2'b00, 3'b100};
      4'hB: return {4'b0011, 2'b01, 3'b100};
      4'hD: return {4'b0000, 2'b00, 3'b010};
      4'hE: return {4'b0100, 2'b00, 3'b100};
      4'hF: return {4'b0100, 2'b01, 3'b100};
      default: return 9'd0;
    endcase
  endfunction

  function automatic bit is_two(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC, 4'hF};
  endfunction

  function automatic bit sets_flags(input logic [3:0] op);
    return op inside {4'h2, 4'h3, 4'hA, 4'hB, 4'hE, 4'hF};
  endfunction

  function automatic bit jump_taken(input logic [3:0] op, input logic fc, input logic fz);
    case (op)
      4'h0: return fc;
      4'h1: return !fc;
      4'h8: return fz;
      4'h9: return !fz;
      4'hC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] strobes();
    return {23'd0, alu_f, b_sel, acc_load, out_load, ram_we};
  endfunction

  // Steps one full instruction from FETCH and updates the model.
  task automatic run_instr(input logic c_in, input logic z_in);
    logic [11:0] a0, a1, a_next;
    logic [7:0]  b0, b1;
    logic [3:0]  op;
    bit          two;
    a0  = m_pc;
    a1  = a0 + 12'd1;
    b0  = rom[a0];
    op  = b0[7:4];
    two = is_two(op);
    b1  = 8'h00;
    chk("fetch_addr", 32'(prog_addr), 32'(a0));
    tick();
    if (two) begin
      chk("operand_addr", 32'(prog_addr), 32'(a1));
      chk("operand_idle", strobes(), 32'd0);
      b1 = rom[a1];
      tick();
    end
    a_next = two ? a0 + 12'd2 : a1;
    chk("exec_pc", 32'(prog_addr), 32'(a_next));
    chk("exec_ctrl", strobes(), 32'(exp_exec(op)));
    chk("exec_imm", 32'(imm), 32'(b0[3:0]));
    if (two) chk("exec_ram_addr", 32'(ram_addr), 32'({b0[3:0], b1}));
    alu_c = c_in;
    alu_z = z_in;
    tick();
    if (jump_taken(op, m_fc, m_fz)) m_pc = {b0[3:0], b1};
    else                            m_pc = a_next;
    if (sets_flags(op)) begin
      m_fc = c_in;
      m_fz = z_in;
    end
    chk("post_pc", 32'(prog_addr), 32'(m_pc));
    chk("post_flags", 32'({flag_c, flag_z}), 32'({m_fc, m_fz}));
    chk("post_idle", strobes(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[12'h000] = 8'h44;
    rom[12'h001] = 8'h25;
    rom[12'h002] = 8'h81; rom[12'h003] = 8'h23;
    rom[12'h123] = 8'hC0; rom[12'h124] = 8'h10;
    rom[12'h010] = 8'h91; rom[12'h011] = 8'h00;
    rom[12'h012] = 8'h7A; rom[12'h013] = 8'hBC;
    rom[12'h014] = 8'hB5; rom[12'h015] = 8'h67;
    alu_c = 1'b0;
    alu_z = 1'b0;
    reset = 1'b0;
    m_pc = 12'h000; m_fc = 1'b0; m_fz = 1'b0;
    #12;
    chk("reset_pc", 32'(prog_addr), 32'h000);
    chk("reset_idle", strobes(), 32'd0);
    chk("reset_flags", 32'({flag_c, flag_z}), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    run_instr(1'b1, 1'b0);   // LIT 4
    run_instr(1'b1, 1'b1);   // CMPI 5 -> flags 11
    run_instr(1'b0, 1'b0);   // JZ 0x123, taken
    chk("jz_target", 32'(prog_addr), 32'h123);
    run_instr(1'b0, 1'b0);   // JMP 0x010
    run_instr(1'b0, 1'b0);   // JNZ, untaken
    chk("jnz_fallthrough", 32'(prog_addr), 32'h012);
    run_instr(1'b0, 1'b0);   // ST 0xABC

    // ADDM at 0x014, reset asserted during its EXECUTE cycle
    chk("addm_fetch_addr", 32'(prog_addr), 32'h014);
    tick();
    tick();
    chk("addm_exec_ctrl", strobes(), 32'({4'b0011, 2'b01, 3'b100}));
    chk("addm_ram_addr", 32'(ram_addr), 32'h567);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_pc", 32'(prog_addr), 32'h000);
    chk("midreset_idle", strobes(), 32'd0);
    chk("midreset_flags", 32'({flag_c, flag_z}), 32'd0);
    rom[12'h000] = 8'hCF; rom[12'h001] = 8'hFF;
    rom[12'hFFF] = 8'h44;
    @(negedge clock);
    reset = 1'b1;
    m_pc = 12'h000; m_fc = 1'b0; m_fz = 1'b0;

    run_instr(1'b0, 1'b0);   // JMP 0xFFF
    run_instr(1'b0, 1'b0);   // LIT at 0xFFF, pc wraps
    chk("wrap_pc", 32'(prog_addr), 32'h000);
    run_instr(1'b0, 1'b0);   // JMP 0xFFF again
    rom[12'hFFF] = 8'hC2;
    rom[12'h000] = 8'h30;
    run_instr(1'b0, 1'b0);   // JMP at 0xFFF, second byte from 0x000
    chk("wrap_jmp_target", 32'(prog_addr), 32'h230);

    for (int k = 0; k < 400; k++)
      run_instr(1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
